alu_operand_issue: RTL and testbench

- Issue stage directly upstream of the ALU.
- Accepts 32-bit SimpleRISC-style instructions and decodes them into the ALU's one-hot op strobes, isImmediate and imm.
- Reads the architectural register file to produce A/B, and holds the result in a valid/ready output register.
- Owns the register file and a per-register busy scoreboard; the writeback port (ALU result returning) updates both.

---
 rtl/alu_operand_issue_if.sv | 36 +++
 rtl/alu_operand_issue.sv | 161 ++++++++++++++++
 tb/tb_alu_operand_issue.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_issue_if.sv
// Bundles the instruction input, issued-op output and writeback channels of alu_operand_issue.
// The slave modport is the issue stage; the master modport is its surroundings.
interface alu_operand_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_A;
  logic [XLEN-1:0] out_B;
  logic [XLEN-1:0] out_imm;
  logic            out_isImmediate;
  logic [12:0]     out_op;
  logic [3:0]      out_rd;
  logic            out_rd_we;
  logic            out_illegal;

  logic            wb_en;
  logic [3:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_A, out_B, out_imm, out_isImmediate,
           out_op, out_rd, out_rd_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_A, out_B, out_imm, out_isImmediate,
           out_op, out_rd, out_rd_we, out_illegal
  );
endinterface

// File: rtl/alu_operand_issue.sv
// Issue stage ahead of the ALU: decode, register read, busy scoreboard and output register.
// Define ALU_ISSUE_WB_BYPASS_EN to forward same-cycle writeback data into a stalled source.
module alu_operand_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_operand_issue_if.slave io
);
  localparam int RW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  logic [4:0]      opcode;
  logic            imm_sel;
  logic [RW-1:0]   rd;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [1:0]      modifier;
  logic [XLEN-1:0] imm;

  logic            is_alu;
  logic            is_illegal;
  logic            is_not;
  logic            is_mov;
  logic            is_cmp;
  logic            writes_rd;
  logic            use_a;
  logic            use_b;
  logic [12:0]     op_dec;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            stall_a;
  logic            stall_b;
  logic            hazard;
  logic            in_ready;
  logic            accept;
  logic            issue;

  logic            out_valid;
  logic [XLEN-1:0] out_A;
  logic [XLEN-1:0] out_B;
  logic [XLEN-1:0] out_imm;
  logic            out_isImmediate;
  logic [12:0]     out_op;
  logic [RW-1:0]   out_rd;
  logic            out_rd_we;
  logic            out_illegal;

  assign opcode   = io.in_instr[31:27];
  assign imm_sel  = io.in_instr[26];
  assign rd       = io.in_instr[25:22];
  assign rs1      = io.in_instr[21:18];
  assign rs2      = io.in_instr[17:14];
  assign modifier = io.in_instr[17:16];

  always_comb begin
    imm = '0;
    case (modifier)
      2'b00:   imm = {{(XLEN-16){io.in_instr[15]}}, io.in_instr[15:0]};
      2'b10:   imm = XLEN'({io.in_instr[15:0], 16'h0000});
      default: imm = XLEN'(io.in_instr[15:0]);
    endcase
  end

  assign is_alu     = (opcode <= 5'd12);
  assign is_illegal = (opcode >= 5'd14);
  assign is_cmp     = (opcode == 5'd5);
  assign is_not     = (opcode == 5'd8);
  assign is_mov     = (opcode == 5'd9);
  assign op_dec     = is_alu ? (13'd1 << opcode) : 13'd0;
  assign writes_rd  = is_alu && !is_cmp;

  // not/mov take their single source from the rs2 slot; rs2 is a register only when I=0
  assign use_a = is_alu && !is_not && !is_mov;
  assign use_b = is_alu && !imm_sel;

`ifdef ALU_ISSUE_WB_BYPASS_EN
  logic wb_hit_a;
  logic wb_hit_b;
  assign wb_hit_a = io.wb_en && (io.wb_rd == rs1);
  assign wb_hit_b = io.wb_en && (io.wb_rd == rs2);
  assign src_a    = wb_hit_a ? io.wb_data : regs[rs1];
  assign src_b    = wb_hit_b ? io.wb_data : regs[rs2];
  assign stall_a  = busy[rs1] && !wb_hit_a;
  assign stall_b  = busy[rs2] && !wb_hit_b;
`else
  assign src_a    = regs[rs1];
  assign src_b    = regs[rs2];
  assign stall_a  = busy[rs1];
  assign stall_b  = busy[rs2];
`endif

  assign hazard   = (use_a && stall_a) || (use_b && stall_b) || (writes_rd && busy[rd]);
  assign in_ready = rst && !hazard && (!out_valid || io.out_ready);
  assign accept   = io.in_valid && in_ready;
  assign issue    = accept && is_alu;

  // Output register: loads on an issuing handshake, otherwise holds until consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_A           <= '0;
      out_B           <= '0;
      out_imm         <= '0;
      out_isImmediate <= 1'b0;
      out_op          <= '0;
      out_rd          <= '0;
      out_rd_we       <= 1'b0;
      out_illegal     <= 1'b0;
    end else begin
      if (issue) begin
        out_valid       <= 1'b1;
        out_A           <= is_not ? (imm_sel ? imm : src_b) : src_a;
        out_B           <= src_b;
        out_imm         <= imm;
        out_isImmediate <= imm_sel && !is_not;
        out_op          <= op_dec;
        out_rd          <= rd;
        out_rd_we       <= writes_rd;
      end else if (io.out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && is_illegal) begin
        out_illegal <= 1'b1;
      end
    end
  end

  // Busy set is ordered after the writeback clear so a same-register collision leaves it set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (io.wb_en) begin
        regs[io.wb_rd] <= io.wb_data;
        busy[io.wb_rd] <= 1'b0;
      end
      if (issue && writes_rd) begin
        busy[rd] <= 1'b1;
      end
    end
  end

  assign io.in_ready        = in_ready;
  assign io.out_valid       = out_valid;
  assign io.out_A           = out_A;
  assign io.out_B           = out_B;
  assign io.out_imm         = out_imm;
  assign io.out_isImmediate = out_isImmediate;
  assign io.out_op          = out_op;
  assign io.out_rd          = out_rd;
  assign io.out_rd_we       = out_rd_we;
  assign io.out_illegal     = out_illegal;
endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed scenarios plus a randomized run against a behavioural model.
module tb_alu_operand_issue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_operand_issue_if #(.XLEN(32)) bus ();
  alu_operand_issue #(.XLEN(32), .NREG(16)) dut (.clk(clk), .rst(rst), .io(bus));

`ifdef ALU_ISSUE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  // Architectural view of the stage: register values, pending writers and the held op
  logic [31:0] m_regs [16];
  bit          m_busy [16];
  bit          m_ov, m_illegal, m_isimm, m_rdwe, m_I;
  logic [31:0] m_A, m_B, m_imm;
  logic [12:0] m_op;
  logic [3:0]  m_rd;
  logic [4:0]  m_opc;

  function automatic logic [31:0] mk_r(input int opc, input int rd, input int rs1, input int rs2);
    return {opc[4:0], 1'b0, rd[3:0], rs1[3:0], rs2[3:0], 14'd0};
  endfunction

  function automatic logic [31:0] mk_i(input int opc, input int rd, input int rs1, input int md, input int v);
    return {opc[4:0], 1'b1, rd[3:0], rs1[3:0], md[1:0], v[15:0]};
  endfunction

  function automatic logic [31:0] f_imm(input logic [31:0] ins);
    int sv;
    case (ins[17:16])
      2'd0:    begin sv = int'(ins[15:0]); if (sv >= 32768) sv = sv - 65536; return 32'(sv); end
      2'd2:    return 32'(ins[15:0]) * 32'd65536;
      default: return 32'(ins[15:0]);
    endcase
  endfunction

  function automatic bool_t_dummy(input bit b);
    return b;
  endfunction

  function automatic logic [31:0] src_val(input logic [3:0] r);
    if (BYPASS && bus.wb_en && bus.wb_rd == r) return bus.wb_data;
    return m_regs[r];
  endfunction

  function automatic bit waits_on(input logic [3:0] r);
    return m_busy[r] && !(BYPASS && bus.wb_en && bus.wb_rd == r);
  endfunction

  function automatic bit f_ready();
    logic [31:0] ins;
    int opc;
    bit alu, ua, ub, wr;
    ins = bus.in_instr;
    opc = int'(ins[31:27]);
    alu = (opc <= 12);
    ua  = alu && opc != 8 && opc != 9;
    ub  = alu && !ins[26];
    wr  = alu && opc != 5;
    if (ua && waits_on(ins[21:18])) return 1'b0;
    if (ub && waits_on(ins[17:14])) return 1'b0;
    if (wr && m_busy[ins[25:22]]) return 1'b0;
    return !m_ov || bus.out_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_ov = 0; m_illegal = 0; m_isimm = 0; m_rdwe = 0; m_I = 0;
    m_A = '0; m_B = '0; m_imm = '0; m_op = '0; m_rd = '0; m_opc = '0;
  endtask

  // Updates the model for the coming edge from the inputs now on the bus, then crosses the edge
  task automatic advance();
    bit acc;
    logic [31:0] ins;
    int opc;
    ins = bus.in_instr;
    opc = int'(ins[31:27]);
    acc = bus.in_valid && f_ready();
    if (m_ov && bus.out_ready) m_ov = 0;
    if (acc && opc >= 14) m_illegal = 1;
    if (acc && opc <= 12) begin
      m_ov    = 1;
      m_opc   = 5'(opc);
      m_I     = ins[26];
      m_op    = 13'd1 << opc;
      m_rd    = ins[25:22];
      m_rdwe  = (opc != 5);
      m_imm   = f_imm(ins);
      m_isimm = (opc == 8) ? 1'b0 : ins[26];
      m_B     = src_val(ins[17:14]);
      m_A     = (opc == 8) ? (ins[26] ? m_imm : m_B) : src_val(ins[21:18]);
    end
    if (bus.wb_en) begin
      m_regs[bus.wb_rd] = bus.wb_data;
      m_busy[bus.wb_rd] = 1'b0;
    end
    if (acc && opc <= 12 && opc != 5) m_busy[ins[25:22]] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_instr = '0; bus.out_ready = 1;
    bus.wb_en = 0; bus.wb_rd = '0; bus.wb_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.in_valid = 1; bus.in_instr = mk_i(0, 1, 2, 0, 5);
    model_reset();
    #12;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b want 0", bus.out_valid); else passed++;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %0b want 0", bus.in_ready); else passed++;
    checks++; if (bus.out_illegal !== 1'b0) $display("[TB] FAIL reset_illegal got %0b want 0", bus.out_illegal); else passed++;
    checks++; if (bus.out_op !== 13'h0) $display("[TB] FAIL reset_out_op got %h want 0", bus.out_op); else passed++;
    bus.in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_imm();
    bus.in_valid = 1; bus.in_instr = mk_i(0, 1, 2, 0, 5); bus.out_ready = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL add_in_ready got %0b want 1", bus.in_ready); else passed++;
    advance();
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL add_valid got %0b want 1", bus.out_valid); else passed++;
    checks++; if (bus.out_op !== 13'h0001) $display("[TB] FAIL add_op got %h want 0001", bus.out_op); else passed++;
    checks++; if (bus.out_isImmediate !== 1'b1) $display("[TB] FAIL add_isimm got %0b want 1", bus.out_isImmediate); else passed++;
    checks++; if (bus.out_imm !== 32'h5) $display("[TB] FAIL add_imm got %h want 5", bus.out_imm); else passed++;
    checks++; if (bus.out_rd !== 4'd1 || bus.out_rd_we !== 1'b1) $display("[TB] FAIL add_rd got %0d/%0b want 1/1", bus.out_rd, bus.out_rd_we); else passed++;
    bus.in_valid = 0; bus.wb_en = 1; bus.wb_rd = 1; bus.wb_data = 32'h11;
    advance();
    bus.wb_en = 0;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL add_drain got %0b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_not();
    bus.wb_en = 1; bus.wb_rd = 3; bus.wb_data = 32'h12345678;
    advance();
    bus.wb_en = 0;
    bus.in_valid = 1; bus.in_instr = mk_r(8, 4, 0, 3);
    advance();
    bus.in_valid = 0;
    checks++; if (bus.out_A !== 32'h12345678) $display("[TB] FAIL not_A got %h want 12345678", bus.out_A); else passed++;
    checks++; if (bus.out_isImmediate !== 1'b0) $display("[TB] FAIL not_isimm got %0b want 0", bus.out_isImmediate); else passed++;
    checks++; if (bus.out_op !== 13'h0100) $display("[TB] FAIL not_op got %h want 0100", bus.out_op); else passed++;
    bus.wb_en = 1; bus.wb_rd = 4; bus.wb_data = 32'hEDCBA987;
    advance();
    bus.wb_en = 0;
  endtask

  task automatic test_stall();
    bus.in_valid = 1; bus.in_instr = mk_r(0, 5, 1, 1); bus.out_ready = 1;
    advance();
    bus.out_ready = 0; bus.in_instr = mk_r(1, 6, 5, 1);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready got %0b want 0", bus.in_ready); else passed++;
      advance();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_op !== 13'h0001 || bus.out_rd !== 4'd5 || bus.out_A !== 32'h11)
        $display("[TB] FAIL stall_hold got v%0b op%h rd%0d A%h want v1 op0001 rd5 A11", bus.out_valid, bus.out_op, bus.out_rd, bus.out_A); else passed++;
    end
    bus.out_ready = 1; bus.wb_en = 1; bus.wb_rd = 5; bus.wb_data = 32'd7;
    #1;
    checks++; if (bus.in_ready !== BYPASS) $display("[TB] FAIL stall_wb_ready got %0b want %0b", bus.in_ready, BYPASS); else passed++;
    advance();
    bus.wb_en = 0;
    if (!BYPASS) begin
      checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL stall_gap got %0b want 0", bus.out_valid); else passed++;
      #1;
      checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL stall_retry_ready got %0b want 1", bus.in_ready); else passed++;
      advance();
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op !== 13'h0002 || bus.out_rd !== 4'd6)
      $display("[TB] FAIL stall_sub got v%0b op%h rd%0d want v1 op0002 rd6", bus.out_valid, bus.out_op, bus.out_rd); else passed++;
    checks++; if (bus.out_A !== 32'd7) $display("[TB] FAIL stall_sub_A got %h want 7", bus.out_A); else passed++;
    bus.in_valid = 0; bus.wb_en = 1; bus.wb_rd = 6; bus.wb_data = 32'h66;
    advance();
    bus.wb_en = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [31:0] want [4];
    ins[0] = mk_i(0, 7, 0, 2, 16'h1234);  want[0] = 32'h12340000;
    ins[1] = mk_i(0, 8, 0, 0, 16'hFFFF);  want[1] = 32'hFFFFFFFF;
    ins[2] = mk_i(0, 9, 0, 1, 16'hFFFF);  want[2] = 32'h0000FFFF;
    ins[3] = mk_i(0, 10, 0, 3, 16'h8001); want[3] = 32'h00008001;
    bus.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1; bus.in_instr = ins[k];
      #1;
      checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL b2b_ready%0d got %0b want 1", k, bus.in_ready); else passed++;
      advance();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== want[k])
        $display("[TB] FAIL b2b_imm%0d got v%0b %h want v1 %h", k, bus.out_valid, bus.out_imm, want[k]); else passed++;
    end
    bus.in_valid = 0;
    for (int k = 7; k <= 10; k++) begin
      bus.wb_en = 1; bus.wb_rd = 4'(k); bus.wb_data = 32'(k * 3);
      advance();
    end
    bus.wb_en = 0;
  endtask

  task automatic test_illegal_cmp();
    bus.in_valid = 1; bus.in_instr = mk_r(16, 1, 2, 3); bus.out_ready = 1;
    advance();
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL illegal_valid got %0b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_illegal !== 1'b1) $display("[TB] FAIL illegal_flag got %0b want 1", bus.out_illegal); else passed++;
    bus.in_instr = mk_r(5, 9, 1, 2);
    advance();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_op !== 13'h0020) $display("[TB] FAIL cmp_op got v%0b %h want v1 0020", bus.out_valid, bus.out_op); else passed++;
    checks++; if (bus.out_rd_we !== 1'b0) $display("[TB] FAIL cmp_rd_we got %0b want 0", bus.out_rd_we); else passed++;
    bus.in_instr = mk_r(0, 9, 1, 2);
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL cmp_no_busy got %0b want 1", bus.in_ready); else passed++;
    advance();
    checks++; if (bus.out_illegal !== 1'b1) $display("[TB] FAIL illegal_sticky got %0b want 1", bus.out_illegal); else passed++;
    bus.in_valid = 0; bus.wb_en = 1; bus.wb_rd = 9; bus.wb_data = 32'h99;
    advance();
    bus.wb_en = 0;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 500; n++) begin
      ins = $urandom;
      ins[31:27] = 5'($urandom_range(0, 13));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = ins;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.wb_en     = ($urandom_range(0, 1) == 1);
      bus.wb_rd     = 4'($urandom_range(0, 15));
      bus.wb_data   = $urandom;
      #1;
      checks++; if (bus.in_ready !== f_ready()) $display("[TB] FAIL rnd_ready@%0d got %0b want %0b", n, bus.in_ready, f_ready()); else passed++;
      advance();
      checks++; if (bus.out_valid !== m_ov) $display("[TB] FAIL rnd_valid@%0d got %0b want %0b", n, bus.out_valid, m_ov); else passed++;
      checks++; if (bus.out_illegal !== m_illegal) $display("[TB] FAIL rnd_illegal@%0d got %0b want %0b", n, bus.out_illegal, m_illegal); else passed++;
      if (m_ov) begin
        checks++; if (bus.out_op !== m_op || bus.out_rd !== m_rd || bus.out_rd_we !== m_rdwe)
          $display("[TB] FAIL rnd_ctl@%0d got %h/%0d/%0b want %h/%0d/%0b", n, bus.out_op, bus.out_rd, bus.out_rd_we, m_op, m_rd, m_rdwe); else passed++;
        checks++; if (bus.out_isImmediate !== m_isimm || bus.out_imm !== m_imm)
          $display("[TB] FAIL rnd_imm@%0d got %0b/%h want %0b/%h", n, bus.out_isImmediate, bus.out_imm, m_isimm, m_imm); else passed++;
        if (m_opc != 5'd9) begin
          checks++; if (bus.out_A !== m_A) $display("[TB] FAIL rnd_A@%0d got %h want %h", n, bus.out_A, m_A); else passed++;
        end
        if (!m_I) begin
          checks++; if (bus.out_B !== m_B) $display("[TB] FAIL rnd_B@%0d got %h want %h", n, bus.out_B, m_B); else passed++;
        end
      end
    end
    idle_inputs();
    for (int r = 0; r < 16; r++) begin
      if (m_busy[r]) begin
        bus.wb_en = 1; bus.wb_rd = 4'(r); bus.wb_data = 32'(r);
        advance();
      end
    end
    bus.wb_en = 0;
    advance();
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1; bus.in_instr = mk_r(0, 2, 1, 1); bus.out_ready = 0;
    advance();
    bus.in_valid = 0;
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL rmid_pre_valid got %0b want 1", bus.out_valid); else passed++;
    #3;
    rst = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_rd !== 4'd0) $display("[TB] FAIL rmid_valid got %0b/%0d want 0/0", bus.out_valid, bus.out_rd); else passed++;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_illegal !== 1'b0) $display("[TB] FAIL rmid_ready_ill got %0b/%0b want 0/0", bus.in_ready, bus.out_illegal); else passed++;
    model_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    bus.in_valid = 1; bus.in_instr = mk_r(0, 3, 2, 2); bus.out_ready = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rmid_no_stall got %0b want 1", bus.in_ready); else passed++;
    advance();
    bus.in_valid = 0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_A !== 32'h0) $display("[TB] FAIL rmid_A got v%0b %h want v1 0", bus.out_valid, bus.out_A); else passed++;
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_not();
    test_stall();
    test_back_to_back();
    test_illegal_cmp();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
